sine_voice_scheduler: RTL and testbench

//   Time-multiplexes one shared sine look-up ROM among N_VOICES phase accumulators (polyphony).
//   On each internal sample tick, visits every voice round-robin, fetches its ROM sample and mixes
//   the enabled voices into one 8-bit unsigned sample for the R2R/PMOD output stage.

---
 rtl/sine_voice_scheduler_pkg.sv | 16 +
 rtl/sine_voice_scheduler_voice_phase_step.sv | 26 ++
 rtl/sine_voice_scheduler.sv | 137 +++++++++++++
 tb/tb_sine_voice_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sine_voice_scheduler_pkg.sv
// Shared constants and FSM state type for the polyphonic sine voice scheduler.
package sine_voice_scheduler_pkg;

  localparam int         TABLE_LEN = 180;
  localparam logic [7:0] MIDSCALE  = 8'h80;
  localparam int         ROM_LAT   = 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACCUM,
    DONE
  } state_e;

endpackage

// File: rtl/sine_voice_scheduler_voice_phase_step.sv
// Combinational phase advance: {int,frac} + step, with the integer part wrapped modulo TABLE_LEN.
module voice_phase_step #(
  parameter int TABLE_LEN = 180,
  parameter int IDX_W     = 8,
  parameter int FRAC_W    = 8
) (
  input  logic [IDX_W+FRAC_W-1:0] phase_in,
  input  logic [IDX_W+FRAC_W-1:0] step_in,
  output logic [IDX_W+FRAC_W-1:0] phase_out
);

  localparam int PH_W = IDX_W + FRAC_W;

  logic [PH_W:0]  sum;
  logic [IDX_W:0] int_w;

  // The second compare only fires for illegal steps; it keeps the address in range regardless.
  always_comb begin
    sum   = {1'b0, phase_in} + {1'b0, step_in};
    int_w = sum[PH_W:FRAC_W];
    if (int_w >= (IDX_W+1)'(TABLE_LEN)) int_w = int_w - (IDX_W+1)'(TABLE_LEN);
    if (int_w >= (IDX_W+1)'(TABLE_LEN)) int_w = '0;
    phase_out = {int_w[IDX_W-1:0], sum[FRAC_W-1:0]};
  end

endmodule

// File: rtl/sine_voice_scheduler.sv
// Round-robin scheduler sharing one sine ROM among N_VOICES phase accumulators and mixing
// the enabled voices into a single unsigned 8-bit sample once per sample tick.
module sine_voice_scheduler #(
  parameter int N_VOICES   = 4,
  parameter int TABLE_LEN  = sine_voice_scheduler_pkg::TABLE_LEN,
  parameter int IDX_W      = 8,
  parameter int FRAC_W     = 8,
  parameter int SAMPLE_DIV = 4630,
  parameter int MIX_SHIFT  = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_VOICES-1:0]                 voice_en,
  input  logic [N_VOICES*(IDX_W+FRAC_W)-1:0]  step_flat,
  input  logic                                ovr_clr,
  output logic [IDX_W-1:0]                    lut_addr,
  input  logic [7:0]                          lut_data,
  output logic [7:0]                          sample_out,
  output logic                                sample_valid,
  output logic                                busy,
  output logic                                overrun
);

  import sine_voice_scheduler_pkg::*;

  localparam int PH_W   = IDX_W + FRAC_W;
  localparam int VIDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int ACC_W  = 8 + MIX_SHIFT + 1;

  state_e                   state_q, state_d;
  logic [VIDX_W-1:0]        voice_q, voice_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [PH_W-1:0]          phase_q [N_VOICES];
  logic [PH_W-1:0]          phase_d [N_VOICES];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [7:0]               sample_out_q, sample_out_d;
  logic [IDX_W-1:0]         lut_addr_q, lut_addr_d;
  logic                     overrun_q, overrun_d;

  logic                     tick;
  logic [PH_W-1:0]          step_sel;
  logic [PH_W-1:0]          phase_next;
  logic signed [8:0]        delta;

  assign tick     = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
  assign step_sel = step_flat[int'(voice_q)*PH_W +: PH_W];

  voice_phase_step #(
    .TABLE_LEN (TABLE_LEN),
    .IDX_W     (IDX_W),
    .FRAC_W    (FRAC_W)
  ) u_phase_step (
    .phase_in  (phase_q[voice_q]),
    .step_in   (step_sel),
    .phase_out (phase_next)
  );

  // One voice occupies three slots: ISSUE drives the address, WAIT covers ROM latency,
  // ACCUM consumes the data and moves that voice's phase on.
  always_comb begin
    state_d      = state_q;
    voice_d      = voice_q;
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    phase_d      = phase_q;
    acc_d        = acc_q;
    sample_out_d = sample_out_q;
    lut_addr_d   = lut_addr_q;
    overrun_d    = overrun_q;
    delta        = $signed({1'b0, lut_data}) - 9'sd128;

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = ISSUE;
          voice_d = '0;
          acc_d   = '0;
        end
      end
      ISSUE: begin
        lut_addr_d = phase_q[voice_q][PH_W-1:FRAC_W];
        state_d    = WAIT;
      end
      WAIT: state_d = ACCUM;
      ACCUM: begin
        if (voice_en[voice_q]) begin
          acc_d            = acc_q + {{(ACC_W-9){delta[8]}}, delta};
          phase_d[voice_q] = phase_next;
        end else begin
          phase_d[voice_q] = '0;
        end
        if (voice_q == VIDX_W'(N_VOICES - 1)) begin
          state_d      = DONE;
          sample_out_d = 8'(acc_d >>> MIX_SHIFT) + MIDSCALE;
        end else begin
          voice_d = voice_q + 1'b1;
          state_d = ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Clear first so a dropped tick in the same cycle still leaves overrun set.
    if (ovr_clr) overrun_d = 1'b0;
    if (tick && (state_q != IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      voice_q      <= '0;
      cnt_q        <= '0;
      phase_q      <= '{default: '0};
      acc_q        <= '0;
      sample_out_q <= MIDSCALE;
      lut_addr_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      voice_q      <= voice_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      acc_q        <= acc_d;
      sample_out_q <= sample_out_d;
      lut_addr_q   <= lut_addr_d;
      overrun_q    <= overrun_d;
    end
  end

  assign lut_addr     = lut_addr_q;
  assign sample_out   = sample_out_q;
  assign sample_valid = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Bench for sine_voice_scheduler: a per-tick arithmetic model of the mix plus directed literal checks.
module tb_sine_voice_scheduler;

  localparam int NV   = 4;
  localparam int TLEN = 180;
  localparam int DIV  = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  voice_en;
  logic [63:0] step_flat;
  logic        ovr_clr;
  logic [7:0]  lut_addr;
  logic [7:0]  lut_data;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic        busy;
  logic        overrun;

  logic        rst_n_o;
  logic        ovr_clr_o;
  logic [3:0]  voice_en_o  = 4'b0000;
  logic [63:0] step_flat_o = 64'd0;
  logic [7:0]  lut_addr_o;
  logic [7:0]  lut_data_o  = 8'h00;
  logic [7:0]  sample_out_o;
  logic        sample_valid_o;
  logic        busy_o;
  logic        overrun_o;

  bit          force_on;
  logic [7:0]  force_val;

  int checks = 0;
  int errors = 0;

  int m_cnt, cd, exp_out, exp_next, obs_addr0;
  int mph      [NV];
  int exp_addr [NV];

  always #5 clk = ~clk;

  sine_voice_scheduler #(.SAMPLE_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .voice_en(voice_en), .step_flat(step_flat), .ovr_clr(ovr_clr),
    .lut_addr(lut_addr), .lut_data(lut_data), .sample_out(sample_out),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  // Deliberately too-short tick period so ticks land while the sequence is still running.
  sine_voice_scheduler #(.SAMPLE_DIV(8)) dut_ovr (
    .clk(clk), .rst_n(rst_n_o), .voice_en(voice_en_o), .step_flat(step_flat_o), .ovr_clr(ovr_clr_o),
    .lut_addr(lut_addr_o), .lut_data(lut_data_o), .sample_out(sample_out_o),
    .sample_valid(sample_valid_o), .busy(busy_o), .overrun(overrun_o)
  );

  always @(posedge clk) lut_data <= force_on ? force_val : lut_addr;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Model: each tick computes the whole sample at once from the current inputs; cd counts
  // the clocks left until the sample is presented.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   = 0;
      cd      = 0;
      exp_out = 128;
      for (int v = 0; v < NV; v++) mph[v] = 0;
    end else begin
      if (cd == 2) exp_out = exp_next;
      if (cd != 0) cd = cd - 1;
      if (m_cnt == DIV - 1) begin
        int sum, data;
        m_cnt = 0;
        sum   = 0;
        for (int v = 0; v < NV; v++) begin
          exp_addr[v] = mph[v] / 256;
          data = force_on ? int'(force_val) : exp_addr[v];
          if (voice_en[v]) begin
            sum    += data - 128;
            mph[v]  = (mph[v] + int'(step_flat[v*16 +: 16])) % (TLEN * 256);
          end else begin
            mph[v] = 0;
          end
        end
        exp_next = (sum >>> 2) + 128;
        cd = 3 * NV + 1;
      end else begin
        m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    check_output("sample_valid", int'(sample_valid), int'(cd == 1));
    check_output("busy", int'(busy), int'(cd != 0));
    check_output("sample_out", int'(sample_out), exp_out);
    check_output("overrun_main", int'(overrun), 0);
    check_output("lut_addr_range", int'(lut_addr < 8'(TLEN)), 1);
    check_output("lut_addr_o_range", int'(lut_addr_o < 8'(TLEN)), 1);
    if (cd >= 3 && cd <= 12 && ((12 - cd) % 3 == 0))
      check_output("lut_addr_voice", int'(lut_addr), exp_addr[(12 - cd) / 3]);
    if (cd == 12) obs_addr0 = int'(lut_addr);
  end

  task automatic apply_stimulus(input logic [3:0] en, input logic [15:0] s0, input logic [15:0] s1,
                                input logic [15:0] s2, input logic [15:0] s3,
                                input bit fon, input logic [7:0] fval);
    voice_en  = en;
    step_flat = {s3, s2, s1, s0};
    force_on  = fon;
    force_val = fval;
  endtask

  task automatic wait_sample(output int s, output int a0);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        ok = 1;
        break;
      end
    end
    check_output("sample_arrives", int'(ok), 1);
    s  = int'(sample_out);
    a0 = obs_addr0;
  endtask

  initial begin
    int s, a, cnt;
    bit found;
    int e4 [5] = '{0, 0, 1, 1, 2};

    rst_n = 1'b0; rst_n_o = 1'b0; ovr_clr = 1'b0; ovr_clr_o = 1'b0;
    apply_stimulus(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check_output("rst_sample_out", int'(sample_out), 128);
    check_output("rst_valid", int'(sample_valid), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_overrun", int'(overrun), 0);
    check_output("rst_lut_addr", int'(lut_addr), 0);
    check_output("rst_ovr_dut_overrun", int'(overrun_o), 0);
    check_output("rst_ovr_dut_busy", int'(busy_o), 0);
    check_output("rst_ovr_dut_sample", int'(sample_out_o), 128);
    #2 rst_n = 1'b1; rst_n_o = 1'b1;

    $display("[TB] idle voices give midscale");
    for (int i = 0; i < 3; i++) begin
      wait_sample(s, a);
      check_output("idle_midscale", s, 128);
    end

    $display("[TB] single voice, integer step");
    apply_stimulus(4'b0001, 16'h0100, 16'h0, 16'h0, 16'h0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      wait_sample(s, a);
      check_output("step1_addr", a, i);
      if (i == 0) check_output("step1_first_sample", s, 96);
    end

    $display("[TB] half step advances every second tick");
    apply_stimulus(4'b0000, 16'h0100, 16'h0, 16'h0, 16'h0, 1'b0, 8'h00);
    wait_sample(s, a);
    apply_stimulus(4'b0001, 16'h0080, 16'h0, 16'h0, 16'h0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      wait_sample(s, a);
      check_output("half_step_addr", a, e4[i]);
    end

    $display("[TB] wrap from 178");
    apply_stimulus(4'b0000, 16'h0200, 16'h0, 16'h0, 16'h0, 1'b0, 8'h00);
    wait_sample(s, a);
    apply_stimulus(4'b0001, 16'h0200, 16'h0, 16'h0, 16'h0, 1'b0, 8'h00);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      wait_sample(s, a);
      if (a == 178) begin
        found = 1;
        break;
      end
    end
    check_output("reach_178", int'(found), 1);
    wait_sample(s, a);
    check_output("wrap_178_to_0", a, 0);

    $display("[TB] wrap from 179");
    apply_stimulus(4'b0000, 16'h0200, 16'h0, 16'h0, 16'h0, 1'b0, 8'h00);
    wait_sample(s, a);
    apply_stimulus(4'b0001, 16'h0100, 16'h0, 16'h0, 16'h0, 1'b0, 8'h00);
    wait_sample(s, a);
    apply_stimulus(4'b0001, 16'h0200, 16'h0, 16'h0, 16'h0, 1'b0, 8'h00);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      wait_sample(s, a);
      if (a == 179) begin
        found = 1;
        break;
      end
    end
    check_output("reach_179", int'(found), 1);
    wait_sample(s, a);
    check_output("wrap_179_to_1", a, 1);

    $display("[TB] full-scale mixes");
    apply_stimulus(4'b1111, 16'h0100, 16'h0333, 16'h1000, 16'h0001, 1'b1, 8'hFF);
    wait_sample(s, a);
    check_output("all_ff", s, 255);
    apply_stimulus(4'b1111, 16'h0100, 16'h0333, 16'h1000, 16'h0001, 1'b1, 8'h00);
    wait_sample(s, a);
    check_output("all_00", s, 0);
    apply_stimulus(4'b1011, 16'h0100, 16'h0333, 16'h1000, 16'h0001, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) wait_sample(s, a);

    $display("[TB] reset in the middle of a sequence");
    apply_stimulus(4'b1111, 16'h0500, 16'h0333, 16'h1000, 16'h0701, 1'b0, 8'h00);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cd == 11) begin
        found = 1;
        break;
      end
    end
    check_output("reach_accum", int'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_sample_out", int'(sample_out), 128);
    check_output("midrst_valid", int'(sample_valid), 0);
    check_output("midrst_busy", int'(busy), 0);
    check_output("midrst_lut_addr", int'(lut_addr), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (sample_valid) cnt++;
    end
    check_output("no_partial_sample", cnt, 0);
    wait_sample(s, a);

    $display("[TB] overrun with short tick period");
    check_output("overrun_set", int'(overrun_o), 1);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (sample_valid_o) cnt++;
    end
    check_output("dropped_ticks_samples", cnt, 4);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sample_valid_o) begin
        found = 1;
        break;
      end
    end
    check_output("ovr_sample_arrives", int'(found), 1);
    ovr_clr_o = 1'b1;
    @(negedge clk);
    ovr_clr_o = 1'b0;
    check_output("overrun_cleared", int'(overrun_o), 0);
    repeat (10) @(negedge clk);
    check_output("overrun_still_clear", int'(overrun_o), 0);
    ovr_clr_o = 1'b1;
    @(negedge clk);
    ovr_clr_o = 1'b0;
    check_output("overrun_set_wins", int'(overrun_o), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
